// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit bridging the control FSM to a word-wide single-port memory
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses; otherwise they are force-aligned.
module lsu_mem_port #(
  parameter int byte_addr_p = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [2:0]             funct3_i,
  input  logic [byte_addr_p-1:0] addr_i,
  input  logic [31:0]            wdata_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [31:0]            rdata_o,
  output logic [byte_addr_p-3:0] mem_addr_o,
  output logic                   mem_rd_en_o,
  output logic                   mem_wr_en_o,
  output logic [31:0]            mem_wdata_o,
  input  logic [31:0]            mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

  state_t      state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic illegal;
  logic req_err;
  logic word_store;

  always_comb begin
    illegal    = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) || (we_i && funct3_i[2]);
    word_store = we_i && (funct3_i[1:0] == 2'b10);
`ifdef LSU_MISALIGN_TRAP_EN
    req_err = illegal
           || ((funct3_i[1:0] == 2'b01) && addr_i[0])
           || ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
    // Force-alignment falls out naturally: W ignores addr[1:0], H selects its lane with addr[1] only.
    req_err = illegal;
`endif
  end

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   load_ext = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   load_ext = {{16{h[15] & ~f3[2]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic half, input logic [1:0] lane,
                                              input logic [15:0] d, input logic [31:0] w);
    store_merge = w;
    if (half) store_merge[{lane[1], 4'b0000} +: 16] = d;
    else      store_merge[{lane, 3'b000} +: 8]      = d[7:0];
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      store_q     <= 1'b0;
      funct3_q    <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            store_q    <= we_i;
            funct3_q   <= funct3_i;
            lane_q     <= addr_i[1:0];
            wdata_q    <= wdata_i[15:0];
            mem_addr_o <= addr_i[byte_addr_p-1:2];
            if (req_err) begin
              err_o <= 1'b1;
              state <= DONE;
            end else if (word_store) begin
              mem_wdata_o <= wdata_i;
              state       <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          // Sub-word stores merge into the word just read; loads extend it.
          if (store_q) begin
            mem_wdata_o <= store_merge(funct3_q[0], lane_q, wdata_q, mem_rdata_i);
            state       <= WRITE;
          end else begin
            rdata_o <= load_ext(funct3_q, lane_q, mem_rdata_i);
            state   <= DONE;
          end
        end
        WRITE: state <= DONE;
        DONE: begin
          err_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state == IDLE);
  assign done_o      = (state == DONE);
  assign mem_rd_en_o = (state == READ);
  assign mem_wr_en_o = (state == WRITE);

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - scoreboard testbench for lsu_mem_port with a behavioural word memory
// Expected values follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic [9:0]  mem_addr_o;
  logic        mem_rd_en_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_port #(.byte_addr_p(12)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rd_en_o (mem_rd_en_o),
    .mem_wr_en_o (mem_wr_en_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata)
  );

  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_wr_en_o) mem[mem_addr_o] <= mem_wdata_o;
    if (mem_rd_en_o) mem_rdata <= mem[mem_addr_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          acc;
    int          lat;
    bit          err;
    bit          chk_rd;
    logic [31:0] rdata;
    bit          has_rd;
    bit          has_wr;
    int          wlat;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int rd_seen = 0, wr_seen = 0, wr_total = 0, done_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=strobe expected=none (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares every strobe and completion against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_i) begin
      rd_seen = 0;
      wr_seen = 0;
    end else begin
      if (mem_rd_en_o && mem_wr_en_o) fail_evt("rd_wr_overlap");
      if (mem_rd_en_o) begin
        if (sb.size() == 0) fail_evt("unexpected_rd");
        else begin
          rd_seen++;
          chk("rd_cycle", cyc - sb[0].acc, 1);
          chk("rd_addr", {22'd0, mem_addr_o}, {22'd0, sb[0].addr});
        end
      end
      if (mem_wr_en_o) begin
        wr_total++;
        if (sb.size() == 0) fail_evt("unexpected_wr");
        else begin
          wr_seen++;
          chk("wr_cycle", cyc - sb[0].acc, sb[0].wlat);
          chk("wr_addr", {22'd0, mem_addr_o}, {22'd0, sb[0].addr});
          chk("wr_data", mem_wdata_o, sb[0].wdata);
        end
      end
      if (done_o) begin
        done_total++;
        if (sb.size() == 0) fail_evt("unexpected_done");
        else begin
          chk("done_cycle", cyc - sb[0].acc, sb[0].lat);
          chk("err", {31'd0, err_o}, {31'd0, sb[0].err});
          if (sb[0].chk_rd) chk("rdata", rdata_o, sb[0].rdata);
          chk("rd_count", rd_seen, {31'd0, sb[0].has_rd});
          chk("wr_count", wr_seen, {31'd0, sb[0].has_wr});
          chk("ready_in_done", {31'd0, ready_o}, 32'd0);
          void'(sb.pop_front());
          rd_seen = 0;
          wr_seen = 0;
        end
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] wd, input exp_t e, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 50) begin @(negedge clk); n++; end
    if (!ready_o) begin
      chk("ready_timeout", {31'd0, ready_o}, 32'd1);
      return;
    end
    e.acc = cyc;
    sb.push_back(e);
    we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd; req_i = 1'b1;
    @(posedge clk); #1;
    // Disturb every input after acceptance; the latched copy must be used.
    we_i = ~we; funct3_i = 3'b111; addr_i = ~a; wdata_i = ~wd;
    if (!hold) req_i = 1'b0;
    else begin
      n = 0;
      @(negedge clk);
      while (!done_o && n < 20) begin @(negedge clk); n++; end
      req_i = 1'b0;
      if (!done_o) chk("hold_done_timeout", {31'd0, done_o}, 32'd1);
    end
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rd);
    exp_t e;
    e = '{default: 0};
    e.lat = 3; e.has_rd = 1; e.chk_rd = 1; e.rdata = rd; e.addr = a[11:2];
    issue(1'b0, f3, a, 32'h0, e, 1'b0);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                          input logic [31:0] wexp, input bit hold);
    exp_t e;
    e = '{default: 0};
    e.has_wr = 1; e.addr = a[11:2]; e.wdata = wexp;
    if (f3 == 3'b010) begin e.lat = 2; e.wlat = 1; end
    else begin e.lat = 4; e.wlat = 3; e.has_rd = 1; end
    issue(1'b1, f3, a, wd, e, hold);
  endtask

  task automatic do_err(input bit we, input logic [2:0] f3, input logic [11:0] a);
    exp_t e;
    e = '{default: 0};
    e.lat = 1; e.err = 1;
    issue(we, f3, a, 32'h12345678, e, 1'b0);
  endtask

  initial begin
    int n;
    int w0, d0;
    exp_t e;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b0; addr_i = '0; wdata_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr_o}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en_o}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en_o}, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    #1 rst_i = 1'b0;

    preload(10'd0, 32'h80FF1234);
    preload(10'd1, 32'h8899AABB);
    do_load(3'b010, 12'h004, 32'h8899AABB);
    do_load(3'b000, 12'h003, 32'hFFFFFF80);
    do_load(3'b100, 12'h003, 32'h00000080);
    do_load(3'b001, 12'h002, 32'hFFFF80FF);
    do_load(3'b101, 12'h002, 32'h000080FF);

    preload(10'd1, 32'h11223344);
    do_store(3'b000, 12'h006, 32'hDEADBEEF, 32'h11EF3344, 1'b0);
    do_load(3'b010, 12'h004, 32'h11EF3344);
    do_store(3'b010, 12'h004, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    do_load(3'b010, 12'h004, 32'hCAFEF00D);

`ifdef LSU_MISALIGN_TRAP_EN
    do_err(1'b0, 3'b001, 12'h003);
    do_err(1'b0, 3'b010, 12'h005);
`else
    do_load(3'b001, 12'h003, 32'hFFFF80FF);
    do_load(3'b010, 12'h005, 32'hCAFEF00D);
`endif
    do_err(1'b0, 3'b011, 12'h004);
    do_err(1'b1, 3'b100, 12'h004);
    do_err(1'b0, 3'b110, 12'h000);

    // req_i stays high for the whole SH: exactly one transaction may result.
    do_store(3'b001, 12'h006, 32'h0000BEEF, 32'hBEEFF00D, 1'b1);
    do_load(3'b010, 12'h004, 32'hBEEFF00D);
    do_load(3'b000, 12'h005, 32'hFFFFFFF0);
    do_load(3'b101, 12'h006, 32'h0000BEEF);

    // Reset pulsed during the CAPTURE cycle of an SB.
    preload(10'd2, 32'h55667788);
    @(negedge clk);
    n = 0;
    while (!ready_o && n < 50) begin @(negedge clk); n++; end
    e = '{default: 0};
    e.acc = cyc; e.lat = 4; e.has_rd = 1; e.addr = 10'd2;
    sb.push_back(e);
    we_i = 1'b1; funct3_i = 3'b000; addr_i = 12'h008; wdata_i = 32'h000000AA; req_i = 1'b1;
    @(posedge clk); #1 req_i = 1'b0;
    @(posedge clk); #1;
    w0 = wr_total; d0 = done_total;
    rst_i = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ready_o}, 32'd1);
    chk("midrst_wr_en", {31'd0, mem_wr_en_o}, 32'd0);
    @(negedge clk); #1;
    rst_i = 1'b0;
    sb.delete();
    rd_seen = 0; wr_seen = 0;
    repeat (6) @(negedge clk);
    chk("midrst_no_write", wr_total - w0, 32'd0);
    chk("midrst_no_done", done_total - d0, 32'd0);
    chk("midrst_ready_after", {31'd0, ready_o}, 32'd1);
    do_load(3'b010, 12'h008, 32'h55667788);

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("drain", sb.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit between the multi-cycle RISC-V control FSM and the single-port word-wide data/instruction memory. Accepts one load or store request at a time from control, converts byte/halfword/word accesses into word-aligned memory cycles, and sign/zero-extends load data. The memory has no byte enables, so sub-word stores use an internal read-modify-write. Completion is signalled to control with a one-cycle pulse.

## Interface
- byte_addr_p, 12, byte address width; memory word address is byte_addr_p-2 bits
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  1  request strobe; accepted only in a cycle where ready_o=1
- we_i  in  1  1=store, 0=load
- funct3_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  byte_addr_p  byte address
- wdata_i  in  32  store data, low-order bits used for B/H
- ready_o  out  1  idle, can accept a request
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o; access suppressed
- rdata_o  out  32  extended load data; valid with done_o, held until the next done_o
- mem_addr_o  out  byte_addr_p-2  word address
- mem_rd_en_o  out  1  read strobe; mem_rdata_i valid the following cycle
- mem_wr_en_o  out  1  full-word write strobe
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data, one cycle after mem_rd_en_o

## Operation
- States: IDLE, READ, CAPTURE, WRITE, DONE. ready_o=1 only in IDLE.
- On acceptance, we_i, funct3_i, addr_i and wdata_i are latched. Later input changes are ignored. req_i outside IDLE is ignored, with no queuing.
- Load: IDLE→READ→CAPTURE→DONE.
- Word store: IDLE→WRITE→DONE.
- B/H store: IDLE→READ→CAPTURE→WRITE→DONE.
- Error: IDLE→DONE with err_o=1 and no memory strobes.
- Little-endian lanes: the byte lane is addr[1:0] and the halfword lane is addr[1].
  - Load B/H: extract the lane, then sign-extend (000/001) or zero-extend (100/101).
  - Store B/H: CAPTURE replaces the lane of the read word with wdata_i[7:0] or wdata_i[15:0]. All other lanes are preserved.
- Illegal funct3 (011, 110, 111, or 100/101 with we_i=1) always takes the error path.
- Misaligned access is H with addr[0]=1, or W with addr[1:0]≠0. Handling is set under Configuration.
- mem_addr_o = latched addr[byte_addr_p-1:2]. It is held from READ/WRITE through DONE.

## Timing
- All outputs are registered or decoded from the state register.
- Reset values:
  - state IDLE, ready_o=1
  - done_o=0, err_o=0
  - rdata_o=0, mem_addr_o=0
  - mem_rd_en_o=0, mem_wr_en_o=0, mem_wdata_o=0
- Request accepted at edge k (req_i=1 in IDLE):
  - Load: mem_rd_en_o high in cycle k+1; data sampled at the end of cycle k+2; done_o and rdata_o in cycle k+3. ready_o is back at 1 in cycle k+4.
  - Word store: mem_wr_en_o high in cycle k+1; done_o in cycle k+2.
  - B/H store: mem_rd_en_o in k+1, merge in k+2, mem_wr_en_o in k+3, done_o in k+4.
  - Error: done_o and err_o in cycle k+1.
- Each strobe is high for exactly one cycle. mem_rd_en_o and mem_wr_en_o are never high in the same cycle.
- A request cannot be accepted in the DONE cycle. The earliest next acceptance is the cycle after done_o.
- rst_i mid-operation: state returns to IDLE immediately. Strobes drop asynchronously and no pending write is ever issued. done_o is not pulsed.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned accesses take the error path, with err_o=1 and no memory access.
- LSU_MISALIGN_TRAP_EN undefined: misaligned accesses are force-aligned and executed normally, with err_o=0.
  - H: addr[0] is treated as 0.
  - W: addr[1:0] is treated as 0.

## Test plan
- Reset, memory word 1 = 0x8899AABB, LW at addr 0x004 → mem_rd_en_o at k+1 with mem_addr_o=1; done_o at k+3 with rdata_o=0x8899AABB and err_o=0.
- Word = 0x80FF1234, LB at addr 0x003 → rdata_o=0xFFFFFF80; LBU at 0x003 → 0x00000080; LH at 0x002 → 0xFFFF80FF; LHU at 0x002 → 0x000080FF.
- Word 0x11223344 at addr 0x004, SB at 0x006 with wdata 0xDEADBEEF → mem_wr_en_o at k+3 with mem_wdata_o=0x11EF3344; done_o at k+4. SW at 0x004 with 0xCAFEF00D → write at k+1 with no read, done_o at k+2.
- LH at addr 0x003:
  - With LSU_MISALIGN_TRAP_EN: done_o and err_o at k+1, no strobes.
  - Without it: reads the halfword at 0x002, err_o=0.
- funct3=011 load → err_o=1 at k+1. funct3=100 with we_i=1 → err_o=1, no mem_wr_en_o.
- req_i held high during a busy SH → exactly one transaction. rst_i pulsed in the CAPTURE cycle of an SB → no mem_wr_en_o, no done_o, ready_o=1 after reset.
